// File: rtl/sig_drain_pkg.sv
// ---------------------------------------------------------------------------
// sig_drain_pkg
//   Shared constants and elaboration helpers for the sig_drain endpoint.
//   No ports (package).
// ---------------------------------------------------------------------------
package sig_drain_pkg;

    // Headroom the buffer needs beyond the upstream latency: one entry for
    // the word arriving on the edge the stall is computed, one for the
    // cycle the registered stall takes to become visible.
    localparam int SIG_DRAIN_MIN_SLACK = 2;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sig_drain_fifo.sv
// ---------------------------------------------------------------------------
// sig_drain_fifo
//   First-word-fall-through synchronous FIFO. rdata always shows the head
//   entry; a word written on edge t is visible after edge t (no bypass).
//   Pointers carry an extra MSB so full and empty are distinguishable.
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset (pointers/level only)
//   push       in   write request
//   pop        in   read request (ignored while empty)
//   wdata      in   write data
//   rdata      out  head entry (don't-care while empty)
//   push_ok    out  push accepted this cycle
//   pop_ok     out  pop performed this cycle
//   level      out  registered occupancy
//   level_nxt  out  occupancy after the coming edge
//   full       out  level == FIFO_DEPTH
//   empty      out  level == 0
// ---------------------------------------------------------------------------
module sig_drain_fifo
    import sig_drain_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          push_ok,
    output logic                          pop_ok,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [$clog2(FIFO_DEPTH):0]   level_nxt,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    if (!is_pow2(FIFO_DEPTH)) begin : g_bad_fifo_depth
        $error("sig_drain_fifo: FIFO_DEPTH (%0d) must be a power of 2", FIFO_DEPTH);
    end

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        // Same slot index but opposite lap bit: writer is a full lap ahead.
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop && !empty;
        // When full, a same-cycle pop frees the head slot; the write lands in
        // that slot at the edge while the head is still being read out.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + LW'(push_ok);
        rd_ptr_d = rd_ptr_q + LW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    assign level     = level_q;
    assign level_nxt = level_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sig_drain.sv
// ---------------------------------------------------------------------------
// sig_drain
//   Sink endpoint for a valid-only, fixed-latency (DEPTH-stage) pipeline.
//   Absorbs the no-backpressure stream into a FWFT FIFO, re-presents it as
//   valid/ready, and raises a registered stall early enough that a source
//   honouring it can never overflow the buffer.
//
// Ports
//   clk          in   clock
//   rstn         in   asynchronous active-low reset
//   sig_in_vld   in   upstream valid (no backpressure)
//   sig_in       in   upstream data
//   in_stall     out  registered stop request to the launching side
//   sig_out_vld  out  output valid
//   sig_out_rdy  in   consumer ready
//   sig_out      out  output data, zero while sig_out_vld=0
//   level        out  registered occupancy
//   ovf_err      out  sticky overflow flag
//   ovf_clr      in   synchronous clear of ovf_err (set wins)
// ---------------------------------------------------------------------------
module sig_drain
    import sig_drain_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sig_in_vld,
    input  logic [WIDTH-1:0]              sig_in,
    output logic                          in_stall,
    output logic                          sig_out_vld,
    input  logic                          sig_out_rdy,
    output logic [WIDTH-1:0]              sig_out,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf_err,
    input  logic                          ovf_clr
);

    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    // Once the stall is visible, up to DEPTH words may still be in flight,
    // so it must rise with exactly DEPTH free entries left.
    localparam int THR = FIFO_DEPTH - DEPTH;

    if (FIFO_DEPTH < DEPTH + SIG_DRAIN_MIN_SLACK) begin : g_bad_depth
        $error("sig_drain: FIFO_DEPTH (%0d) must be >= DEPTH+2 (%0d)",
               FIFO_DEPTH, DEPTH + SIG_DRAIN_MIN_SLACK);
    end

    logic [WIDTH-1:0] rdata;
    logic             push_ok;
    logic             pop_ok;
    logic [LW-1:0]    level_nxt;
    logic             full;
    logic             empty;
    logic             pop_req;

    logic             in_stall_q, in_stall_d;
    logic             ovf_err_q,  ovf_err_d;

    sig_drain_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (sig_in_vld),
        .pop       (pop_req),
        .wdata     (sig_in),
        .rdata     (rdata),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .level     (level),
        .level_nxt (level_nxt),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        sig_out_vld = !empty;
        pop_req     = sig_out_vld && sig_out_rdy;
        sig_out     = sig_out_vld ? rdata : '0;

        // Stall tracks the post-edge occupancy so it is aligned with level.
        in_stall_d  = (level_nxt >= LW'(THR));

        ovf_err_d   = ovf_err_q;
        if (sig_in_vld && !push_ok) begin
            ovf_err_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_stall_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            in_stall_q <= in_stall_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign in_stall = in_stall_q;
    assign ovf_err  = ovf_err_q;

    // full and pop_ok are consumed inside the FIFO's acceptance logic; the
    // top only needs their combined effect through push_ok.
    logic unused_ok;
    assign unused_ok = full ^ pop_ok;

endmodule

// File: tb/tb_sig_drain.sv
// ---------------------------------------------------------------------------
// tb_sig_drain
//   Directed bench for sig_drain (WIDTH=8, DEPTH=2, FIFO_DEPTH=8, THR=6).
//   Inputs are driven 1 time unit after each rising edge; outputs are
//   observed at the same point, i.e. they reflect state after that edge.
// ---------------------------------------------------------------------------
module tb_sig_drain;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 2;
    localparam int FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sig_in_vld = 1'b0;
    logic [7:0] sig_in = 8'h00;
    logic       in_stall;
    logic       sig_out_vld;
    logic       sig_out_rdy = 1'b0;
    logic [7:0] sig_out;
    logic [3:0] level;
    logic       ovf_err;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    // Compliant source: a launch flop decision reaches sig_in two cycles later.
    logic       src_p1 = 1'b0, src_p2 = 1'b0;
    logic [7:0] src_d1 = 8'h00, src_d2 = 8'h00;
    logic [7:0] q[$];

    sig_drain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sig_in_vld  (sig_in_vld),
        .sig_in      (sig_in),
        .in_stall    (in_stall),
        .sig_out_vld (sig_out_vld),
        .sig_out_rdy (sig_out_rdy),
        .sig_out     (sig_out),
        .level       (level),
        .ovf_err     (ovf_err),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic src_step(input logic launch, input logic [7:0] data);
        sig_in_vld = src_p2;
        sig_in     = src_d2;
        src_p2     = src_p1;
        src_d2     = src_d1;
        src_p1     = launch;
        src_d1     = launch ? data : 8'h00;
    endtask

    task automatic src_clear();
        src_p1 = 1'b0; src_p2 = 1'b0; src_d1 = 8'h00; src_d2 = 8'h00;
        sig_in_vld = 1'b0; sig_in = 8'h00;
    endtask

    task automatic fill(input logic [7:0] base);
        sig_out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sig_in_vld = 1'b1;
            sig_in     = base + 8'(i);
            tick();
        end
        sig_in_vld = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [7:0] base);
        sig_out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_vld"}, 32'(sig_out_vld), 32'd1);
            chk({tag, "_data"}, 32'(sig_out), 32'(base + 8'(i)));
            tick();
        end
        chk({tag, "_empty_vld"}, 32'(sig_out_vld), 32'd0);
        chk({tag, "_empty_level"}, 32'(level), 32'd0);
        chk({tag, "_empty_data"}, 32'(sig_out), 32'd0);
    endtask

    initial begin
        logic       launch;
        logic [7:0] cnt;
        logic       rdy_r;
        logic       want;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(in_stall), 32'd0);
        chk("rst_vld",   32'(sig_out_vld), 32'd0);
        chk("rst_data",  32'(sig_out), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf",   32'(ovf_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // ---------------- 1: single word latency ----------------
        sig_in_vld  = 1'b1;
        sig_in      = 8'hA5;
        sig_out_rdy = 1'b1;
        #1;
        chk("t1_no_bypass", 32'(sig_out_vld), 32'd0);
        tick();
        sig_in_vld = 1'b0;
        chk("t1_vld",   32'(sig_out_vld), 32'd1);
        chk("t1_data",  32'(sig_out), 32'hA5);
        chk("t1_level", 32'(level), 32'd1);
        tick();
        chk("t1_level_after", 32'(level), 32'd0);
        chk("t1_vld_after",   32'(sig_out_vld), 32'd0);
        chk("t1_stall",       32'(in_stall), 32'd0);

        // ---------------- 2: compliant source fills to 8 ----------------
        src_clear();
        sig_out_rdy = 1'b0;
        cnt = 8'h01;
        for (int k = 0; k < 14; k++) begin
            if (k == 7) begin
                chk("t2_level_k7", 32'(level), 32'd5);
                chk("t2_stall_k7", 32'(in_stall), 32'd0);
            end
            if (k == 8) begin
                chk("t2_level_k8", 32'(level), 32'd6);
                chk("t2_stall_k8", 32'(in_stall), 32'd1);
            end
            chk("t2_ovf", 32'(ovf_err), 32'd0);
            launch = !in_stall;
            src_step(launch, cnt);
            if (launch) cnt = cnt + 8'd1;
            tick();
        end
        src_clear();
        chk("t2_launched", 32'(cnt), 32'h09);
        chk("t2_level",    32'(level), 32'd8);
        chk("t2_ovf_end",  32'(ovf_err), 32'd0);
        drain("t2_drain", 8'h01);
        chk("t2_stall_drop", 32'(in_stall), 32'd0);

        // ---------------- 3: overflow, sticky flag, clear ----------------
        fill(8'h11);
        chk("t3_full_level", 32'(level), 32'd8);
        chk("t3_full_stall", 32'(in_stall), 32'd1);
        sig_in_vld = 1'b1;
        sig_in     = 8'hFF;
        tick();
        chk("t3_ovf_set",   32'(ovf_err), 32'd1);
        chk("t3_level_8",   32'(level), 32'd8);
        ovf_clr = 1'b1;
        tick();
        chk("t3_set_beats_clr", 32'(ovf_err), 32'd1);
        sig_in_vld = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(ovf_err), 32'd0);
        drain("t3_drain", 8'h11);

        // ---------------- 4: full with push+pop, pointer wrap ----------------
        fill(8'h21);
        chk("t4_ovf_pre", 32'(ovf_err), 32'd0);
        sig_out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sig_in_vld = 1'b1;
            sig_in     = 8'h29 + 8'(i);
            chk("t4_head", 32'(sig_out), 32'(8'h21 + 8'(i)));
            tick();
            chk("t4_level", 32'(level), 32'd8);
            chk("t4_ovf",   32'(ovf_err), 32'd0);
        end
        sig_in_vld = 1'b0;
        drain("t4_drain", 8'h25);

        // ---------------- 5: random traffic with scoreboard ----------------
        src_clear();
        q.delete();
        for (int n = 0; n < 10040; n++) begin
            rdy_r = (n >= 10000) ? 1'b1 : ($urandom_range(0, 9) < 3);
            want  = (n < 10000) && ($urandom_range(0, 1) == 1);
            sig_out_rdy = rdy_r;
            chk("t5_level", 32'(level), 32'(q.size()));
            chk("t5_vld",   32'(sig_out_vld), 32'(q.size() != 0));
            chk("t5_stall", 32'(in_stall), 32'(q.size() >= 6));
            chk("t5_ovf",   32'(ovf_err), 32'd0);
            if (q.size() != 0) begin
                chk("t5_data", 32'(sig_out), 32'(q[0]));
                if (rdy_r) void'(q.pop_front());
            end else begin
                chk("t5_data_zero", 32'(sig_out), 32'd0);
            end
            launch = want && !in_stall;
            src_step(launch, 8'($urandom_range(0, 255)));
            if (sig_in_vld && q.size() < 8) q.push_back(sig_in);
            tick();
        end
        src_clear();
        chk("t5_final_level", 32'(level), 32'd0);
        chk("t5_final_model", 32'(q.size()), 32'd0);

        // ---------------- 6: reset mid-operation ----------------
        sig_out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sig_in_vld = 1'b1;
            sig_in     = 8'h41 + 8'(i);
            tick();
        end
        sig_in_vld = 1'b0;
        chk("t6_level5", 32'(level), 32'd5);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_level", 32'(level), 32'd0);
        chk("t6_async_vld",   32'(sig_out_vld), 32'd0);
        chk("t6_async_data",  32'(sig_out), 32'd0);
        chk("t6_async_stall", 32'(in_stall), 32'd0);
        chk("t6_async_ovf",   32'(ovf_err), 32'd0);
        tick();
        chk("t6_hold_level", 32'(level), 32'd0);
        #2;
        rstn = 1'b1;
        sig_in_vld  = 1'b1;
        sig_in      = 8'h3C;
        sig_out_rdy = 1'b1;
        tick();
        sig_in_vld = 1'b0;
        chk("t6_first_vld",   32'(sig_out_vld), 32'd1);
        chk("t6_first_data",  32'(sig_out), 32'h3C);
        chk("t6_first_level", 32'(level), 32'd1);
        tick();
        chk("t6_after_vld",   32'(sig_out_vld), 32'd0);
        chk("t6_after_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
